// File: rtl/sha256_pkg.sv
`default_nettype none
//============================================================================
// Module : sha256_pkg
// Desc   : SHA-256 constants, FSM state type and round/schedule helper functions
// Rev    : 1.0
//============================================================================
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Arguments are w[t-2], w[t-7], w[t-15], w[t-16]
    function automatic logic [31:0] sched_word(input logic [31:0] wm2, input logic [31:0] wm7,
                                               input logic [31:0] wm15, input logic [31:0] wm16);
        return small_sigma1(wm2) + wm7 + small_sigma0(wm15) + wm16;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_round_step.sv
`default_nettype none
//============================================================================
// Module : sha256_round_step
// Desc   : One combinational SHA-256 round; state packed {a,b,c,d,e,f,g,h}
// Rev    : 1.0
//============================================================================
module sha256_round_step
    import sha256_pkg::*;
(
    input  logic [255:0] i_state,
    input  logic [31:0]  i_k,
    input  logic [31:0]  i_w,
    output logic [255:0] o_state
);

    logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    logic [31:0] w_t1, w_t2;

    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_state;

    assign w_t1 = w_h + big_sigma1(w_e) + ch(w_e, w_f, w_g) + i_k + i_w;
    assign w_t2 = big_sigma0(w_a) + maj(w_a, w_b, w_c);

    assign o_state = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule
`default_nettype wire

// File: rtl/sha256_compress_core.sv
`default_nettype none
//============================================================================
// Module : sha256_compress_core
// Desc   : Iterative SHA-256 compression with internal chaining, UNROLL rounds/clk
// Rev    : 1.0
//============================================================================
module sha256_compress_core
    import sha256_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    input  logic         in_first,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_digest,
    output logic         busy
);

    localparam int         ROUND_CYC   = 64 / UNROLL;
    localparam logic [5:0] c_last_rcnt = 6'(ROUND_CYC - 1);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) begin : g_bad_unroll
        $error("sha256_compress_core: UNROLL must be 1, 2, 4, 8 or 16");
    end

    state_t        r_state;
    logic [5:0]    r_rcnt;
    logic [255:0]  r_work;
    logic [255:0]  r_base;
    logic [255:0]  r_chain;
    logic [255:0]  r_digest;
    logic [31:0]   r_w [0:15];
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_busy;

    logic [255:0]  w_round_out;
    logic [255:0]  w_final;
    logic [31:0]   w_ext [0:15+UNROLL];
    logic [31:0]   w_next_win [0:15];

    // Round chain kept as separate per-stage signals so each stage is its own net
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
        logic [255:0] w_st_in;
        logic [255:0] w_st_out;
        logic [5:0]   w_kidx;

        if (gi == 0) begin : g_head
            assign w_st_in = r_work;
        end else begin : g_link
            assign w_st_in = g_round[gi-1].w_st_out;
        end

        assign w_kidx = r_rcnt * 6'(UNROLL) + 6'(gi);

        sha256_round_step u_step (
            .i_state (w_st_in),
            .i_k     (K[w_kidx]),
            .i_w     (r_w[gi]),
            .o_state (w_st_out)
        );
    end

    assign w_round_out = g_round[UNROLL-1].w_st_out;

    // Extended window: new words may depend on words generated earlier this cycle
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_ext[i] = r_w[i];
        end
        for (int j = 0; j < UNROLL; j++) begin
            w_ext[16+j] = sched_word(w_ext[14+j], w_ext[9+j], w_ext[1+j], w_ext[j]);
        end
        for (int i = 0; i < 16; i++) begin
            w_next_win[i] = w_ext[i+UNROLL];
        end
    end

    always_comb begin
        w_final = '0;
        for (int i = 0; i < 8; i++) begin
            w_final[255-32*i -: 32] = r_base[255-32*i -: 32] + r_work[255-32*i -: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rcnt      <= '0;
            r_work      <= '0;
            r_base      <= '0;
            r_chain     <= IV;
            r_digest    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_work     <= in_first ? IV : r_chain;
                        r_base     <= in_first ? IV : r_chain;
                        for (int i = 0; i < 16; i++) begin
                            r_w[i] <= in_block[511-32*i -: 32];
                        end
                        r_rcnt     <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ROUND;
                    end
                end
                ROUND: begin
                    r_work <= w_round_out;
                    r_w    <= w_next_win;
                    if (r_rcnt == c_last_rcnt) begin
                        r_rcnt  <= '0;
                        r_state <= FINAL;
                    end else begin
                        r_rcnt <= r_rcnt + 6'd1;
                    end
                end
                FINAL: begin
                    r_digest    <= w_final;
                    r_chain     <= w_final;
                    r_out_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_digest = r_digest;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sha256_compress_core.sv
`default_nettype none
//============================================================================
// Module : tb_sha256_compress_core
// Desc   : Self-checking bench with a full-schedule SHA-256 reference model
// Rev    : 1.0
//============================================================================
module tb_sha256_compress_core;

    parameter int UNROLL = 1;
    localparam int ROUND_CYC = 64 / UNROLL;

    localparam logic [255:0] IV_TB = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] TWO_B1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] TWO_B2  = {480'h0, 32'h000001c0};
    localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TWO_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_block;
    logic         in_first;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_digest;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    sha256_compress_core #(.UNROLL(UNROLL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_block   (in_block),
        .in_first   (in_first),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_digest (out_digest),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook compression: full 64-word schedule, then 64 rounds, then feed-forward
    function automatic logic [255:0] model_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return res;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out, event never seen (t=%0t)", name, $time);
    endtask

    // Monitor / scoreboard: predicts handshake timing and digests cycle by cycle
    logic [255:0] exp_q [$];
    int           time_q [$];
    logic [255:0] m_chain = IV_TB;
    logic [255:0] last_digest = '0;
    int           cyc = 0;
    int           acc_cnt = 0;
    int           done_cnt = 0;
    int           acc_cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                exp_q.delete();
                time_q.delete();
                m_chain = IV_TB;
            end else begin
                logic idle_e, ov_e, busy_e;
                logic [255:0] d;
                idle_e = (exp_q.size() == 0);
                ov_e   = !idle_e && (cyc >= time_q[0]);
                busy_e = !idle_e && (cyc <  time_q[0]);
                chk("in_ready", {255'b0, in_ready}, {255'b0, idle_e});
                chk("out_valid", {255'b0, out_valid}, {255'b0, ov_e});
                chk("busy", {255'b0, busy}, {255'b0, busy_e});
                if (ov_e) chk("out_digest", out_digest, exp_q[0]);
                if (ov_e && out_valid && out_ready) begin
                    last_digest = out_digest;
                    void'(exp_q.pop_front());
                    void'(time_q.pop_front());
                    done_cnt++;
                end else if (in_valid && in_ready) begin
                    d = model_compress(in_first ? IV_TB : m_chain, in_block);
                    m_chain = d;
                    exp_q.push_back(d);
                    time_q.push_back(cyc + 1 + ROUND_CYC + 1);
                    acc_cyc = cyc + 1;
                    acc_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int start);
        int n = 0;
        while (acc_cnt == start && n < 400) begin tick(); n++; end
        if (acc_cnt == start) timeout("accept");
    endtask

    task automatic send(input logic [511:0] blk, input logic first);
        int s = acc_cnt;
        in_block = blk;
        in_first = first;
        in_valid = 1'b1;
        wait_acc(s);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input logic rand_ready);
        int s = done_cnt;
        int n = 0;
        while (done_cnt == s && n < 400) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        out_ready = 1'b1;
        if (done_cnt == s) timeout("digest");
    endtask

    initial begin
        logic [511:0] blk;
        logic [255:0] d0;
        int a1, ds, s, n;

        rst_n = 1'b0; in_valid = 1'b0; in_block = '0; in_first = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", {255'b0, in_ready}, 256'd1);
        chk("rst_out_valid", {255'b0, out_valid}, 256'd0);
        chk("rst_busy", {255'b0, busy}, 256'd0);
        chk("rst_digest", out_digest, 256'd0);
        rst_n = 1'b1;
        tick();

        chk("model_abc", model_compress(IV_TB, ABC_BLK), ABC_DIG);
        chk("model_two", model_compress(model_compress(IV_TB, TWO_B1), TWO_B2), TWO_DIG);

        send(ABC_BLK, 1'b1);
        wait_done(1'b0);
        chk("abc_digest", last_digest, ABC_DIG);

        send(TWO_B1, 1'b1);
        wait_done(1'b0);
        send(TWO_B2, 1'b0);
        wait_done(1'b0);
        chk("two_block_digest", last_digest, TWO_DIG);

        // Backpressure: digest parked in DONE while a new block waits
        out_ready = 1'b0;
        send(ABC_BLK, 1'b1);
        n = 0;
        while (!out_valid && n < 400) begin tick(); n++; end
        if (!out_valid) timeout("bp_out_valid");
        d0 = out_digest;
        in_block = TWO_B1; in_first = 1'b1; in_valid = 1'b1;
        repeat (20) tick();
        chk("bp_valid_held", {255'b0, out_valid}, 256'd1);
        chk("bp_digest_stable", out_digest, d0);
        chk("bp_in_ready_low", {255'b0, in_ready}, 256'd0);
        ds = done_cnt;
        s  = acc_cnt;
        out_ready = 1'b1;
        wait_acc(s);
        in_valid = 1'b0;
        chk("bp_release_count", 256'(done_cnt), 256'(ds + 1));
        chk("bp_digest", last_digest, ABC_DIG);
        wait_done(1'b0);

        // Reset during rounds must discard the block and restore IV chaining
        for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = $urandom();
        send(blk, 1'b1);
        repeat (ROUND_CYC / 2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        send(ABC_BLK, 1'b0);
        wait_done(1'b0);
        chk("post_reset_abc", last_digest, ABC_DIG);

        // Back-to-back identical blocks
        ds = done_cnt;
        in_block = ABC_BLK; in_first = 1'b1; in_valid = 1'b1;
        wait_acc(acc_cnt);
        a1 = acc_cyc;
        wait_acc(acc_cnt);
        in_valid = 1'b0;
        chk("b2b_spacing", 256'(acc_cyc - a1), 256'(ROUND_CYC + 3));
        chk("b2b_first", last_digest, ABC_DIG);
        chk("b2b_first_count", 256'(done_cnt), 256'(ds + 1));
        wait_done(1'b0);
        chk("b2b_second", last_digest, ABC_DIG);

        // Random blocks, random chaining choice, random consumer stalls
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = $urandom();
            send(blk, (k == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
            wait_done(1'b1);
        end
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
